reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 165 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : In-order retirement buffer with tag-based result broadcast,
//            operand query ports and register-file rename/commit tracking.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        issue_valid,
    input  logic        issue_dest_en,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    output logic [4:0]  issue_tag,
    input  logic        cdb_valid,
    input  logic [4:0]  cdb_tag,
    input  logic [31:0] cdb_value,
    input  logic [4:0]  query_tag1,
    input  logic [4:0]  query_tag2,
    output logic        query_ready1,
    output logic        query_ready2,
    output logic [31:0] query_value1,
    output logic [31:0] query_value2,
    input  logic        flush,
    output logic        rf_rename_en,
    output logic [4:0]  rf_rename_addr,
    output logic [36:0] rf_rename_data,
    output logic        rf_commit_en,
    output logic [4:0]  rf_commit_addr,
    output logic [36:0] rf_commit_data,
    output logic        rf_flush
);
    localparam int                 c_ptr_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_cnt_w     = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [4:0]         c_depth_tag = 5'(DEPTH);

    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_ready;
    logic [DEPTH-1:0]   r_dest_en;
    logic [4:0]         r_rd     [DEPTH];
    logic [31:0]        r_value  [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic [4:0]         r_latest [32];

    logic               w_act;
    logic               w_flush;
    logic               w_accept;
    logic               w_dest_eff;
    logic               w_pop;
    logic               w_cdb_hit;
    logic               w_q1_hit;
    logic               w_q2_hit;
    logic [4:0]         w_head_tag;
    logic [4:0]         w_head_rd;
    logic [4:0]         w_latest_head;
    logic [4:0]         w_commit_state;
    logic [c_ptr_w-1:0] w_cdb_idx;
    logic [c_ptr_w-1:0] w_q1_idx;
    logic [c_ptr_w-1:0] w_q2_idx;

    // Reset held high behaves like rdy low so no strobe escapes during reset.
    assign w_act    = rdy & ~rst;
    assign w_flush  = flush & w_act;
    assign rf_flush = w_flush;

    assign issue_ready    = (r_count < c_depth_cnt) & ~flush;
    assign issue_tag      = 5'(r_tail) + 5'd1;
    assign w_accept       = issue_valid & issue_ready & w_act;
    assign w_dest_eff     = issue_dest_en & (issue_rd != 5'd0);
    assign rf_rename_en   = w_accept & w_dest_eff;
    assign rf_rename_addr = issue_rd;
    assign rf_rename_data = {issue_tag, 32'h0};

    assign w_head_tag     = 5'(r_head) + 5'd1;
    assign w_head_rd      = r_rd[r_head];
    assign w_latest_head  = r_latest[w_head_rd];
    assign w_commit_state = (w_latest_head == w_head_tag) ? 5'd0 : w_latest_head;
    assign w_pop          = r_valid[r_head] & r_ready[r_head] & w_act & ~flush;
    assign rf_commit_en   = w_pop & r_dest_en[r_head];
    assign rf_commit_addr = w_head_rd;
    assign rf_commit_data = {w_commit_state, r_value[r_head]};

    assign w_cdb_idx = c_ptr_w'(cdb_tag - 5'd1);
    assign w_q1_idx  = c_ptr_w'(query_tag1 - 5'd1);
    assign w_q2_idx  = c_ptr_w'(query_tag2 - 5'd1);

    assign w_cdb_hit = cdb_valid & w_act & (cdb_tag != 5'd0) & (cdb_tag <= c_depth_tag)
                     & r_valid[w_cdb_idx] & ~r_ready[w_cdb_idx];

    assign w_q1_hit     = (query_tag1 != 5'd0) & (query_tag1 <= c_depth_tag)
                        & r_valid[w_q1_idx] & r_ready[w_q1_idx];
    assign w_q2_hit     = (query_tag2 != 5'd0) & (query_tag2 <= c_depth_tag)
                        & r_valid[w_q2_idx] & r_ready[w_q2_idx];
    assign query_ready1 = w_q1_hit;
    assign query_ready2 = w_q2_hit;
    assign query_value1 = w_q1_hit ? r_value[w_q1_idx] : 32'h0;
    assign query_value2 = w_q2_hit ? r_value[w_q2_idx] : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= '0;
            r_ready   <= '0;
            r_dest_en <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]    <= '0;
                r_value[i] <= '0;
            end
            for (int i = 0; i < 32; i++) begin
                r_latest[i] <= '0;
            end
        end else if (w_flush) begin
            r_valid <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < 32; i++) begin
                r_latest[i] <= '0;
            end
        end else if (w_act) begin
            if (w_cdb_hit) begin
                r_ready[w_cdb_idx] <= 1'b1;
                r_value[w_cdb_idx] <= cdb_value;
            end
            // Only forget the producer if it is the one retiring; a younger
            // rename of the same register must stay visible.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= (r_head == c_last_ptr) ? '0 : r_head + 1'b1;
                if (rf_commit_en && (w_latest_head == w_head_tag)) begin
                    r_latest[w_head_rd] <= 5'd0;
                end
            end
            // Placed after the commit clear so a same-cycle rename wins.
            if (w_accept) begin
                r_valid[r_tail]   <= 1'b1;
                r_ready[r_tail]   <= 1'b0;
                r_dest_en[r_tail] <= w_dest_eff;
                r_rd[r_tail]      <= issue_rd;
                r_tail            <= (r_tail == c_last_ptr) ? '0 : r_tail + 1'b1;
                if (w_dest_eff) begin
                    r_latest[issue_rd] <= issue_tag;
                end
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Brief    : Self-checking bench for reorder_buffer (vector table, directed
//            corner sequences, random traffic against a queue-based model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
    localparam int c_depth = 16;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        issue_valid;
    logic        issue_dest_en;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  issue_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [4:0]  query_tag1;
    logic [4:0]  query_tag2;
    logic        query_ready1;
    logic        query_ready2;
    logic [31:0] query_value1;
    logic [31:0] query_value2;
    logic        flush;
    logic        rf_rename_en;
    logic [4:0]  rf_rename_addr;
    logic [36:0] rf_rename_data;
    logic        rf_commit_en;
    logic [4:0]  rf_commit_addr;
    logic [36:0] rf_commit_data;
    logic        rf_flush;

    reorder_buffer #(.DEPTH(c_depth)) u_dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_dest_en(issue_dest_en), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .query_tag1(query_tag1), .query_tag2(query_tag2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_value1(query_value1), .query_value2(query_value2),
        .flush(flush),
        .rf_rename_en(rf_rename_en), .rf_rename_addr(rf_rename_addr), .rf_rename_data(rf_rename_data),
        .rf_commit_en(rf_commit_en), .rf_commit_addr(rf_commit_addr), .rf_commit_data(rf_commit_data),
        .rf_flush(rf_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: in-flight instructions kept in program order.
    typedef struct {
        logic [4:0]  tag;
        logic [4:0]  rd;
        logic        dest;
        logic        done;
        logic [31:0] val;
    } ent_t;

    ent_t       m_q[$];
    logic [4:0] m_latest [32];
    logic [4:0] m_next_tag;
    logic       e_accept;
    logic       e_pop;
    logic       e_commit_en;

    function automatic int find(input logic [4:0] tag);
        for (int i = 0; i < m_q.size(); i++) begin
            if (m_q[i].tag == tag) return i;
        end
        return -1;
    endfunction

    function automatic logic [32:0] q_exp(input logic [4:0] tag);
        int i;
        i = find(tag);
        if (i >= 0 && m_q[i].done) return {1'b1, m_q[i].val};
        return 33'h0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 32; i++) m_latest[i] = 5'd0;
        m_next_tag = 5'd1;
    endtask

    task automatic model_check();
        logic        exp_ready;
        logic [4:0]  st;
        logic [32:0] q1;
        logic [32:0] q2;
        exp_ready = (m_q.size() < c_depth) && !flush;
        chk("issue_ready", issue_ready, exp_ready);
        chk("issue_tag", issue_tag, m_next_tag);
        e_accept = issue_valid && exp_ready && rdy;
        chk("rename_en", rf_rename_en, e_accept && issue_dest_en && (issue_rd != 5'd0));
        chk("rename_addr", rf_rename_addr, issue_rd);
        chk("rename_data", rf_rename_data, {m_next_tag, 32'h0});
        e_pop       = (m_q.size() > 0) && m_q[0].done && rdy && !flush;
        e_commit_en = e_pop && m_q[0].dest;
        chk("commit_en", rf_commit_en, e_commit_en);
        if (e_commit_en) begin
            st = (m_latest[m_q[0].rd] == m_q[0].tag) ? 5'd0 : m_latest[m_q[0].rd];
            chk("commit_addr", rf_commit_addr, m_q[0].rd);
            chk("commit_data", rf_commit_data, {st, m_q[0].val});
        end
        chk("rf_flush", rf_flush, flush && rdy);
        q1 = q_exp(query_tag1);
        q2 = q_exp(query_tag2);
        chk("query_ready1", query_ready1, q1[32]);
        chk("query_value1", query_value1, q1[31:0]);
        chk("query_ready2", query_ready2, q2[32]);
        chk("query_value2", query_value2, q2[31:0]);
    endtask

    task automatic model_edge();
        int   i;
        ent_t e;
        if (rdy) begin
            if (flush) begin
                model_reset();
            end else begin
                if (e_pop) begin
                    if (e_commit_en && m_latest[m_q[0].rd] == m_q[0].tag) m_latest[m_q[0].rd] = 5'd0;
                    void'(m_q.pop_front());
                end
                if (cdb_valid) begin
                    i = find(cdb_tag);
                    if (i >= 0 && !m_q[i].done) begin
                        e = m_q[i];
                        e.done = 1'b1;
                        e.val  = cdb_value;
                        m_q[i] = e;
                    end
                end
                if (e_accept) begin
                    e.tag  = m_next_tag;
                    e.rd   = issue_rd;
                    e.dest = issue_dest_en && (issue_rd != 5'd0);
                    e.done = 1'b0;
                    e.val  = 32'h0;
                    m_q.push_back(e);
                    if (e.dest) m_latest[issue_rd] = m_next_tag;
                    m_next_tag = (m_next_tag == 5'd16) ? 5'd1 : m_next_tag + 5'd1;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; issue_valid = 1'b0; issue_dest_en = 1'b1; issue_rd = 5'd0;
        cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_value = 32'h0;
        query_tag1 = 5'd0; query_tag2 = 5'd0; flush = 1'b0;
    endtask

    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        query_tag1  = 5'd1;
        rst = 1'b1;
        #1;
        chk("rst_issue_ready", issue_ready, 1'b1);
        chk("rst_issue_tag", issue_tag, 5'd1);
        chk("rst_rename_en", rf_rename_en, 1'b0);
        chk("rst_commit_en", rf_commit_en, 1'b0);
        chk("rst_rf_flush", rf_flush, 1'b0);
        chk("rst_query_ready1", query_ready1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_reset();
    endtask

    task automatic issue(input logic [4:0] rd);
        idle_inputs();
        issue_valid = 1'b1;
        issue_rd    = rd;
        settle();
        advance();
    endtask

    task automatic bcast(input logic [4:0] tag, input logic [31:0] val);
        idle_inputs();
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_value = val;
        settle();
        advance();
    endtask

    typedef struct {
        logic        iv;
        logic        de;
        logic [4:0]  rd;
        logic        cv;
        logic [4:0]  ct;
        logic [31:0] cval;
        logic        rdy;
        logic        e_ren;
        logic [4:0]  e_tag;
        logic        e_cen;
        logic [4:0]  e_caddr;
        logic [36:0] e_cdata;
    } vec_t;

    function automatic vec_t mk(input int iv, input int de, input int rd, input int cv,
                                input int ct, input logic [31:0] cval, input int rd_y,
                                input int ren, input int tag, input int cen, input int caddr,
                                input int cst, input logic [31:0] cvv);
        vec_t v;
        v.iv = 1'(iv); v.de = 1'(de); v.rd = 5'(rd); v.cv = 1'(cv); v.ct = 5'(ct);
        v.cval = cval; v.rdy = 1'(rd_y); v.e_ren = 1'(ren); v.e_tag = 5'(tag);
        v.e_cen = 1'(cen); v.e_caddr = 5'(caddr); v.e_cdata = {5'(cst), cvv};
        return v;
    endfunction

    vec_t vt[23];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           iv de rd cv ct cval          rdy ren tag cen addr st cdata
        vt[0]  = mk(1, 1, 5, 0, 0, 32'h0,        1,  1,  1,  0,  0,   0, 32'h0);
        vt[1]  = mk(0, 1, 0, 0, 0, 32'h0,        1,  0,  2,  0,  0,   0, 32'h0);
        vt[2]  = mk(0, 1, 0, 1, 1, 32'h11,       1,  0,  2,  0,  0,   0, 32'h0);
        vt[3]  = mk(0, 1, 0, 0, 0, 32'h0,        1,  0,  2,  1,  5,   0, 32'h11);
        vt[4]  = mk(1, 1, 3, 0, 0, 32'h0,        1,  1,  2,  0,  0,   0, 32'h0);
        vt[5]  = mk(0, 1, 0, 1, 2, 32'hDEADBEEF, 1,  0,  3,  0,  0,   0, 32'h0);
        vt[6]  = mk(0, 1, 0, 0, 0, 32'h0,        1,  0,  3,  1,  3,   0, 32'hDEADBEEF);
        vt[7]  = mk(1, 1, 3, 0, 0, 32'h0,        1,  1,  3,  0,  0,   0, 32'h0);
        vt[8]  = mk(1, 1, 3, 0, 0, 32'h0,        1,  1,  4,  0,  0,   0, 32'h0);
        vt[9]  = mk(0, 1, 0, 1, 3, 32'hA,        1,  0,  5,  0,  0,   0, 32'h0);
        vt[10] = mk(0, 1, 0, 1, 4, 32'hB,        1,  0,  5,  1,  3,   4, 32'hA);
        vt[11] = mk(0, 1, 0, 0, 0, 32'h0,        1,  0,  5,  1,  3,   0, 32'hB);
        vt[12] = mk(1, 1, 7, 0, 0, 32'h0,        1,  1,  5,  0,  0,   0, 32'h0);
        vt[13] = mk(0, 1, 0, 1, 5, 32'h55,       1,  0,  6,  0,  0,   0, 32'h0);
        vt[14] = mk(0, 1, 0, 0, 0, 32'h0,        0,  0,  6,  0,  0,   0, 32'h0);
        vt[15] = mk(1, 1, 9, 1, 5, 32'h99,       0,  0,  6,  0,  0,   0, 32'h0);
        vt[16] = mk(0, 1, 0, 0, 0, 32'h0,        1,  0,  6,  1,  7,   0, 32'h55);
        vt[17] = mk(1, 0, 4, 0, 0, 32'h0,        1,  0,  6,  0,  0,   0, 32'h0);
        vt[18] = mk(1, 1, 0, 0, 0, 32'h0,        1,  0,  7,  0,  0,   0, 32'h0);
        vt[19] = mk(0, 1, 0, 1, 6, 32'h66,       1,  0,  8,  0,  0,   0, 32'h0);
        vt[20] = mk(0, 1, 0, 1, 7, 32'h77,       1,  0,  8,  0,  0,   0, 32'h0);
        vt[21] = mk(0, 1, 0, 0, 0, 32'h0,        1,  0,  8,  0,  0,   0, 32'h0);
        vt[22] = mk(0, 1, 0, 1, 0, 32'h1,        1,  0,  8,  0,  0,   0, 32'h0);

        rst = 1'b1;
        idle_inputs();
        do_reset();

        for (int k = 0; k < 23; k++) begin
            idle_inputs();
            issue_valid = vt[k].iv; issue_dest_en = vt[k].de; issue_rd = vt[k].rd;
            cdb_valid = vt[k].cv; cdb_tag = vt[k].ct; cdb_value = vt[k].cval; rdy = vt[k].rdy;
            query_tag1 = 5'(k % 8);
            settle();
            chk($sformatf("vec%0d_rename_en", k), rf_rename_en, vt[k].e_ren);
            chk($sformatf("vec%0d_issue_tag", k), issue_tag, vt[k].e_tag);
            chk($sformatf("vec%0d_commit_en", k), rf_commit_en, vt[k].e_cen);
            if (vt[k].e_cen) begin
                chk($sformatf("vec%0d_commit_addr", k), rf_commit_addr, vt[k].e_caddr);
                chk($sformatf("vec%0d_commit_data", k), rf_commit_data, vt[k].e_cdata);
            end
            advance();
        end

        // Full buffer, tag wrap, out-of-order completion retiring in order.
        do_reset();
        for (int i = 0; i < c_depth; i++) issue(5'(i + 1));
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd20;
        settle();
        chk("full_issue_ready", issue_ready, 1'b0);
        chk("full_issue_tag", issue_tag, 5'd1);
        chk("full_rename_en", rf_rename_en, 1'b0);
        advance();
        bcast(5'd2, 32'h22);
        idle_inputs();
        cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_value = 32'h111;
        settle();
        chk("ooo_no_commit", rf_commit_en, 1'b0);
        advance();
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd20;
        settle();
        chk("ooo_c1_en", rf_commit_en, 1'b1);
        chk("ooo_c1_addr", rf_commit_addr, 5'd1);
        chk("ooo_c1_data", rf_commit_data, {5'd0, 32'h111});
        chk("full_pop_issue_ready", issue_ready, 1'b0);
        advance();
        settle();
        chk("ooo_c2_en", rf_commit_en, 1'b1);
        chk("ooo_c2_addr", rf_commit_addr, 5'd2);
        chk("ooo_c2_data", rf_commit_data, {5'd0, 32'h22});
        chk("after_pop_issue_ready", issue_ready, 1'b1);
        advance();

        // Flush with four in flight and a ready head.
        do_reset();
        for (int i = 1; i <= 4; i++) issue(5'(i));
        bcast(5'd1, 32'h1234);
        idle_inputs();
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd6;
        settle();
        chk("flush_rf_flush", rf_flush, 1'b1);
        chk("flush_commit_en", rf_commit_en, 1'b0);
        chk("flush_issue_ready", issue_ready, 1'b0);
        chk("flush_rename_en", rf_rename_en, 1'b0);
        advance();
        idle_inputs();
        query_tag1 = 5'd1;
        settle();
        chk("post_flush_rf_flush", rf_flush, 1'b0);
        chk("post_flush_issue_tag", issue_tag, 5'd1);
        chk("post_flush_query", query_ready1, 1'b0);
        advance();

        // Asynchronous reset mid-operation with a retirable head.
        for (int i = 1; i <= 3; i++) issue(5'(i + 10));
        bcast(5'd1, 32'hCAFE);
        idle_inputs();
        query_tag1 = 5'd1;
        settle();
        chk("pre_rst_commit_en", rf_commit_en, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_commit_en", rf_commit_en, 1'b0);
        chk("async_rst_issue_tag", issue_tag, 5'd1);
        chk("async_rst_query", query_ready1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        settle();
        chk("post_rst_commit_en", rf_commit_en, 1'b0);
        advance();

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            rdy           = ($urandom % 10) != 0;
            issue_valid   = ($urandom % 4) != 0;
            issue_dest_en = ($urandom % 8) != 0;
            issue_rd      = 5'($urandom % 32);
            cdb_valid     = ($urandom % 10) < 7;
            cdb_value     = $urandom;
            if (m_q.size() > 0 && ($urandom % 8) != 0) cdb_tag = m_q[$urandom % m_q.size()].tag;
            else cdb_tag = 5'($urandom % 32);
            if (m_q.size() > 0 && ($urandom % 2) != 0) query_tag1 = m_q[$urandom % m_q.size()].tag;
            else query_tag1 = 5'($urandom % 32);
            if (m_q.size() > 0 && ($urandom % 2) != 0) query_tag2 = m_q[$urandom % m_q.size()].tag;
            else query_tag2 = 5'($urandom % 32);
            flush = ($urandom % 80) == 0;
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
